// File: rtl/mem_responder.sv
// mem_responder: single-beat backing memory with byte-masked writes and fixed read latency.
// Define MEM_RESPONDER_BOUNDS_EN to reject out-of-range addresses and raise a sticky err.
module mem_responder #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic                   mem_req_rw,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [DATA_BITS-1:0]   mem_resp_data,
  output logic                   err
);
  typedef enum logic [1:0] {IDLE, WDATA, RDWAIT, RESP} state_t;
  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  oob_q, oob_d, err_q, err_d, oob_req, we;
  logic [DATA_BITS-1:0]  mem_q [2**DEPTH_LOG2];
`ifdef MEM_RESPONDER_BOUNDS_EN
  assign oob_req = |mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];
`else
  logic unused_addr;
  assign unused_addr = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];
  assign oob_req = 1'b0;
`endif
  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    cnt_d              = cnt_q;
    oob_d              = oob_q;
    err_d              = err_q;
    we                 = 1'b0;
    mem_req_ready      = 1'b0;
    mem_req_data_ready = 1'b0;
    mem_resp_valid     = 1'b0;
    case (state_q)
      IDLE: begin
        mem_req_ready = 1'b1;
        cnt_d         = 4'(LATENCY - 1);
        addr_d        = mem_req_valid ? mem_req_addr[DEPTH_LOG2-1:0] : addr_q;
        oob_d         = mem_req_valid ? oob_req : oob_q;
        err_d         = err_q | (mem_req_valid & oob_req);
        state_d       = mem_req_valid ? (mem_req_rw ? WDATA : (LATENCY == 1 ? RESP : RDWAIT)) : IDLE;
      end
      WDATA: begin
        mem_req_data_ready = 1'b1;
        we                 = mem_req_data_valid & ~oob_q;
        state_d            = mem_req_data_valid ? IDLE : WDATA;
      end
      RDWAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q <= 4'd1 ? RESP : RDWAIT;
      end
      RESP: begin
        mem_resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      oob_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      oob_q   <= oob_d;
      err_q   <= err_d;
    end
  end
  // Storage is deliberately unreset; reset still blocks a write pending in WDATA.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_BITS / 8; i++)
      if (we && !reset && mem_req_data_mask[i]) mem_q[addr_q][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
  end
  assign mem_resp_data = (state_q == RESP && !oob_q) ? mem_q[addr_q] : '0;
  assign err           = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven write/read vectors plus directed sequences for reset, back-pressure and busy cases.
module tb_mem_responder;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mem_req_valid = 1'b0;
  logic         mem_req_ready;
  logic [27:0]  mem_req_addr = '0;
  logic         mem_req_rw = 1'b0;
  logic         mem_req_data_valid = 1'b0;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits = '0;
  logic [15:0]  mem_req_data_mask = '0;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic         err;
  int nvec = 0;
  int nfail = 0;

  mem_responder dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rw;
    logic [27:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] PAT  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] ONES = {128{1'b1}};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    @(negedge clk);
    mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = a;
    @(negedge clk);
    mem_req_valid = 1'b0; mem_req_data_valid = 1'b1; mem_req_data_bits = d; mem_req_data_mask = m;
    @(negedge clk);
    mem_req_data_valid = 1'b0;
  endtask

  task automatic do_read(input logic [27:0] a, output logic [127:0] d, output int lat);
    @(negedge clk);
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = a;
    @(negedge clk);
    mem_req_valid = 1'b0;
    lat = 1;
    while (!mem_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = mem_resp_data;
    @(negedge clk);
    chk("resp_one_cycle", 128'(mem_resp_valid), 128'd0);
    chk("ready_after_resp", 128'(mem_req_ready), 128'd1);
  endtask

  vec_t vecs[16];
  logic [127:0] rd;
  int lat;

  initial begin
    vecs[0]  = '{1'b1, 28'h05, PAT, 16'hFFFF, '0};
    vecs[1]  = '{1'b0, 28'h05, '0, '0, PAT};
    vecs[2]  = '{1'b1, 28'h10, ONES, 16'hFFFF, '0};
    vecs[3]  = '{1'b1, 28'h10, '0, 16'h000F, '0};
    vecs[4]  = '{1'b0, 28'h10, '0, '0, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0}};
    vecs[5]  = '{1'b1, 28'h40, 128'hA0A0, 16'hFFFF, '0};
    vecs[6]  = '{1'b1, 28'h41, 128'hA1A1, 16'hFFFF, '0};
    vecs[7]  = '{1'b1, 28'h42, 128'hA2A2, 16'hFFFF, '0};
    vecs[8]  = '{1'b1, 28'h43, 128'hA3A3, 16'hFFFF, '0};
    vecs[9]  = '{1'b0, 28'h40, '0, '0, 128'hA0A0};
    vecs[10] = '{1'b0, 28'h41, '0, '0, 128'hA1A1};
    vecs[11] = '{1'b0, 28'h42, '0, '0, 128'hA2A2};
    vecs[12] = '{1'b0, 28'h43, '0, '0, 128'hA3A3};
    vecs[13] = '{1'b1, 28'h05, '0, 16'hF000, '0};
    vecs[14] = '{1'b0, 28'h05, '0, '0, 128'h00000000_89ABCDEF_01234567_89ABCDEF};
    vecs[15] = '{1'b1, 28'h00, {8{16'h5A5A}}, 16'hFFFF, '0};

    // Async reset: enter RDWAIT, then assert reset between edges.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 28'h0;
    @(negedge clk);
    mem_req_valid = 1'b0;
    chk("busy_in_rdwait", 128'(mem_req_ready), 128'd0);
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", 128'(mem_req_ready), 128'd1);
    chk("rst_resp_valid", 128'(mem_resp_valid), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_data_ready", 128'(mem_req_data_ready), 128'd0);
    chk("rst_resp_data", mem_resp_data, 128'd0);
    begin
      int pulses = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (i == 1) reset = 1'b0;
        if (mem_resp_valid) pulses++;
      end
      chk("no_resp_after_rst", 128'(pulses), 128'd0);
    end

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rw) do_write(vecs[i].addr, vecs[i].data, vecs[i].mask);
      else begin
        do_read(vecs[i].addr, rd, lat);
        chk($sformatf("vec%0d_data", i), rd, vecs[i].exp);
        chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
      end
    end

    // Write data back-pressure.
    @(negedge clk);
    mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = 28'h30;
    @(negedge clk);
    mem_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_data_ready", 128'(mem_req_data_ready), 128'd1);
      chk("bp_req_ready", 128'(mem_req_ready), 128'd0);
      @(negedge clk);
    end
    mem_req_data_valid = 1'b1; mem_req_data_bits = 128'hBEEF; mem_req_data_mask = 16'hFFFF;
    @(negedge clk);
    mem_req_data_valid = 1'b0;
    chk("bp_ready_after", 128'(mem_req_ready), 128'd1);
    do_read(28'h30, rd, lat);
    chk("bp_readback", rd, 128'hBEEF);

    // Requests offered while busy are ignored; requester withdraws before IDLE.
    @(negedge clk);
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 28'h42;
    @(negedge clk);
    mem_req_rw = 1'b1; mem_req_addr = 28'h41;
    mem_req_data_valid = 1'b1; mem_req_data_bits = '0; mem_req_data_mask = 16'hFFFF;
    lat = 1;
    while (!mem_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_latency", 128'(lat), 128'd4);
    chk("busy_read_data", mem_resp_data, 128'hA2A2);
    mem_req_valid = 1'b0; mem_req_data_valid = 1'b0;
    @(negedge clk);
    chk("busy_not_accepted", 128'(mem_req_ready), 128'd1);
    do_read(28'h41, rd, lat);
    chk("busy_no_write", rd, 128'hA1A1);

    // Reset during WDATA with data present: storage must stay unchanged.
    @(negedge clk);
    mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = 28'h40;
    @(negedge clk);
    mem_req_valid = 1'b0;
    mem_req_data_valid = 1'b1; mem_req_data_bits = ONES; mem_req_data_mask = 16'hFFFF;
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_req_data_valid = 1'b0;
    do_read(28'h40, rd, lat);
    chk("rst_wdata_nowrite", rd, 128'hA0A0);

    // Out-of-range read.
    do_read(28'h100, rd, lat);
    chk("oob_latency", 128'(lat), 128'd4);
`ifdef MEM_RESPONDER_BOUNDS_EN
    chk("oob_data", rd, 128'd0);
    chk("oob_err", 128'(err), 128'd1);
    do_read(28'h43, rd, lat);
    chk("oob_err_sticky", 128'(err), 128'd1);
`else
    chk("oob_alias_data", rd, {8{16'h5A5A}});
    chk("oob_err", 128'(err), 128'd0);
    do_read(28'h43, rd, lat);
    chk("oob_err_quiet", 128'(err), 128'd0);
`endif
    chk("after_oob_data", rd, 128'hA3A3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port backing-memory responder: the memory-side end of the cache's `mem_req_*`/`mem_resp_*` interface. Accepts one 128-bit beat request at a time, performs byte-masked writes into a local storage array, and returns read data after a fixed, parameterized latency. Used as the DRAM stand-in behind the data/instruction caches for simulation and small-memory builds.

## Interface
- `ADDR_BITS`, default 28: beat-address width, matching the cache's `mem_req_addr`.
- `DATA_BITS`, default 128: beat width, `MEM_DATA_BITS`.
- `DEPTH_LOG2`, default 8: log2 of the storage depth in beats (256 × 128 b).
- `LATENCY`, default 4: cycles from read-request acceptance to response; legal range is 1 to 15.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `mem_req_valid` input 1: request present.
- `mem_req_ready` output 1: responder can accept a request.
- `mem_req_addr` input ADDR_BITS: beat address.
- `mem_req_rw` input 1: 1 = write, 0 = read.
- `mem_req_data_valid` input 1: write data present.
- `mem_req_data_ready` output 1: responder accepts write data.
- `mem_req_data_bits` input DATA_BITS: write data.
- `mem_req_data_mask` input DATA_BITS/8: byte enables; bit i covers bits [8i+7:8i].
- `mem_resp_valid` output 1: read data valid, one-cycle pulse. There is no back-pressure.
- `mem_resp_data` output DATA_BITS: read data.
- `err` output 1: sticky bounds error. This port is only meaningful with the configuration macro defined.

## Operation
- FSM states are IDLE, WDATA, RDWAIT and RESP. The responder handles one transaction at a time, with no queueing.
- **IDLE**
  - `mem_req_ready`=1.
  - On `mem_req_valid && mem_req_ready`, the responder latches `addr` and `rw`.
  - If `rw`=1, go to WDATA. If `rw`=0, load the latency counter with LATENCY-1 and go to RDWAIT.
  - If LATENCY=1, go straight to RESP.
- **WDATA**
  - `mem_req_data_ready`=1 and `mem_req_ready`=0.
  - On `mem_req_data_valid`, each byte whose mask bit is set is written into `storage[addr[DEPTH_LOG2-1:0]]`; unmasked bytes are unchanged. Then go to IDLE.
  - Data presented in IDLE, even in the same cycle as the request, is ignored.
- **RDWAIT**
  - The counter decrements each cycle. When it reaches 1, go to RESP.
- **RESP**
  - `mem_resp_valid`=1 for exactly one cycle. `mem_resp_data` = `storage[addr]` read in this cycle. Then go to IDLE.
- **Addressing:** without the configuration macro, address bits at or above DEPTH_LOG2 are ignored, so addresses alias modulo the depth.
- **Storage reset:** storage is not reset; its contents are undefined until written.
- **`mem_resp_data` outside RESP:** drives 0.

## Timing
- **Reset values:** state=IDLE, `mem_req_ready`=1, `mem_req_data_ready`=0, `mem_resp_valid`=0, `mem_resp_data`=0, `err`=0. Reset takes effect immediately, asynchronously.
- **Reset mid-transaction:** an in-flight read or write is abandoned, with no response and no storage write. An accepted but unwritten write leaves storage unchanged.
- **Read:** request handshake at edge T, `mem_resp_valid` high during cycle T+LATENCY, `mem_req_ready` high again in cycle T+LATENCY+1.
- **Write:** request handshake at edge T, `mem_req_data_ready` high from cycle T+1 until the data handshake at edge D, storage updated at D, `mem_req_ready` high in cycle D+1. The minimum write occupancy is 2 cycles.
- **Read-after-write:** a read accepted after the write's data handshake returns the new data.
- **Illegal inputs:** `mem_req_valid` while `mem_req_ready`=0 is ignored; the requester must hold it. Changing `mem_req_addr` or `mem_req_rw` after acceptance has no effect.

## Configuration
- `MEM_RESPONDER_BOUNDS_EN`
  - **Defined:** a request whose `addr[ADDR_BITS-1:DEPTH_LOG2]` is nonzero is out of range.
    - Out-of-range writes still complete the data handshake but leave storage unchanged.
    - Out-of-range reads return all-zero data at normal latency.
    - `err` goes to 1 at the request handshake edge and stays 1 until reset.
  - **Not defined:** addresses alias modulo the depth and `err` is tied 0.

## Test plan
- **Reset state:** assert `reset` mid-cycle, with no clock edge needed -> `mem_req_ready`=1, `mem_resp_valid`=0, `err`=0 immediately.
- **Write then read:**
  - Write addr 0x05, data 0x0123…CDEF, mask 0xFFFF.
  - Then read addr 0x05 with LATENCY=4 -> `mem_resp_valid` asserted exactly 4 cycles after the read handshake, for one cycle, with data 0x0123…CDEF.
- **Masked write:**
  - Write all-ones to addr 0x10.
  - Then write zero with mask 0x000F.
  - Then read -> 0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000.
- **Write data back-pressure:** hold `mem_req_data_valid`=0 for 3 cycles after the request -> `mem_req_data_ready` stays 1 and `mem_req_ready` stays 0. Then assert data -> storage updated and `mem_req_ready`=1 on the next cycle.
- **Cache-line sequence:** 4 back-to-back writes to addrs 0x40–0x43, then 4 reads -> each read returns the matching beat. Requests offered while busy are not accepted.
- **Out-of-range access:**
  - Read addr 0x100 with DEPTH_LOG2=8.
  - With `MEM_RESPONDER_BOUNDS_EN` -> data 0 and `err`=1, sticky.
  - Without the macro -> data equals addr 0x00 contents and `err`=0.
  - Also assert `reset` during RDWAIT -> no `mem_resp_valid` pulse.
